// File: rtl/guess_link_ctrl.sv
// Two-board "guess who" controller: maps right-clicks on the portrait grid to a person ID,
// filters the Pmod link from the peer board, and resolves or mirrors the win/lose verdict.
module guess_link_ctrl #(
   parameter int         ID_W        = 4,
   parameter int         ROWS        = 3,
   parameter int         COLS        = 3,
   parameter int         X0          = 0,
   parameter int         Y0          = 0,
   parameter int         CELL_W      = 100,
   parameter int         CELL_H      = 100,
   parameter int         PITCH_X     = 200,
   parameter int         PITCH_Y     = 200,
   parameter logic [5:0] GUESS_ST    = 6'd2,
   parameter logic [5:0] REVEAL_ST   = 6'd4,
   parameter int         SYNC_STAGES = 2,
   parameter int         STABLE_CYC  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rst_sys,
   input  logic [5:0]        state_bin,
   input  logic [ID_W-1:0]   your_person,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic              mouse_right,
   input  logic [ID_W+3:0]   link_in,
   output logic [ID_W+3:0]   link_out,
   output logic [ID_W-1:0]   selected,
   output logic [1:0]        result,
   output logic              reset_req,
   output logic              link_ok
);

   localparam int LW    = ID_W + 4;
   localparam int PN    = ID_W + 3;
   localparam int RQ    = ID_W + 2;
   localparam int CNT_W = $clog2(STABLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
   localparam logic [LW-1:0] ABSENT_WORD = {1'b1, {(LW-1){1'b0}}};

   generate
      if (ROWS * COLS > (2 ** ID_W) - 1) begin : g_bad_id_w
         $error("guess_link_ctrl: ROWS*COLS does not fit in ID_W");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("guess_link_ctrl: SYNC_STAGES must be at least 2");
      end
      if (STABLE_CYC < 1) begin : g_bad_stable
         $error("guess_link_ctrl: STABLE_CYC must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ARMED, COMPARE, DONE} state_t;

   state_t            state_q;
   logic [LW-1:0]     sync_q [SYNC_STAGES];
   logic [LW-1:0]     synced;
   logic [LW-1:0]     cand_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              accept;
   logic [LW-1:0]     accept_word;
   logic [ID_W+1:0]   peer_q;
   logic [ID_W-1:0]   peer_id;
   logic [1:0]        peer_res;
   logic              mirror_valid;
   logic [1:0]        mirror_res;
   logic              mouse_prev;
   logic              hit;
   logic [ID_W-1:0]   hit_id;
   logic [12:0]       x_lo, x_hi, y_lo, y_hi;
   logic              in_y;
   logic              click_go;

   // Idle sync/filter state looks like an absent peer so link_ok only rises on a real word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= ABSENT_WORD;
      end else begin
         sync_q[0] <= link_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      accept      = 1'b0;
      accept_word = cand_q;
      if (synced != cand_q) begin
         accept      = (STABLE_CYC == 1);
         accept_word = synced;
      end else begin
         accept      = (cnt_q >= CNT_MAX - 1'b1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q    <= ABSENT_WORD;
         cnt_q     <= CNT_MAX;
         peer_q    <= '0;
         link_ok   <= 1'b0;
         reset_req <= 1'b0;
      end else begin
         if (synced != cand_q) begin
            cand_q <= synced;
            cnt_q  <= CNT_W'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_q  <= cnt_q + 1'b1;
         end
         if (accept) begin
            peer_q    <= accept_word[ID_W+1:0];
            link_ok   <= ~accept_word[PN];
            reset_req <= ~accept_word[PN] & accept_word[RQ];
         end
      end
   end

   assign peer_id  = peer_q[ID_W-1:0];
   assign peer_res = peer_q[ID_W+1:ID_W];

   always_comb begin
      mirror_valid = 1'b0;
      mirror_res   = 2'b00;
      if (peer_res == 2'b10) begin
         mirror_valid = 1'b1;
         mirror_res   = 2'b01;
      end else if (peer_res == 2'b01) begin
         mirror_valid = 1'b1;
         mirror_res   = 2'b10;
      end
   end

   // Scan rows then columns so the first hit found is the lowest (r,c) on overlapping cells.
   always_comb begin
      hit    = 1'b0;
      hit_id = '0;
      x_lo   = '0;
      x_hi   = '0;
      y_lo   = '0;
      y_hi   = '0;
      in_y   = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         y_lo = 13'(Y0 + r * PITCH_Y);
         y_hi = y_lo + 13'(CELL_H);
         in_y = ({1'b0, ypos} >= y_lo) && ({1'b0, ypos} <= y_hi);
         for (int c = 0; c < COLS; c++) begin
            x_lo = 13'(X0 + c * PITCH_X);
            x_hi = x_lo + 13'(CELL_W);
            if (!hit && in_y && ({1'b0, xpos} >= x_lo) && ({1'b0, xpos} <= x_hi)) begin
               hit    = 1'b1;
               hit_id = ID_W'(r * COLS + c + 1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mouse_prev <= 1'b0;
      else     mouse_prev <= mouse_right;
   end

   assign click_go = mouse_right && !mouse_prev && (state_bin == GUESS_ST) && hit;

   // A peer reset request overrides everything; a local compare outranks a peer mirror.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         selected <= '0;
         result   <= 2'b00;
      end else if (reset_req) begin
         state_q  <= IDLE;
         selected <= '0;
         result   <= 2'b00;
      end else begin
         if (click_go) selected <= hit_id;
         case (state_q)
            IDLE: begin
               if (link_ok && mirror_valid) begin
                  result  <= mirror_res;
                  state_q <= DONE;
               end else if (selected != '0) begin
                  state_q <= ARMED;
               end
            end
            ARMED: begin
               if (link_ok) begin
                  if (state_bin == REVEAL_ST) begin
                     state_q <= COMPARE;
                  end else if (mirror_valid) begin
                     result  <= mirror_res;
                     state_q <= DONE;
                  end
               end
            end
            COMPARE: begin
               if (link_ok) begin
                  result  <= (peer_id == selected) ? 2'b10 : 2'b01;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign link_out = {1'b0, rst_sys, result, your_person};

endmodule
